multi_phase_signal_ctrl: RTL and testbench

//  Parametrised N-phase intersection controller; generalises the two-road highway/road FSM pair into one block.

---
 rtl/multi_phase_signal_ctrl_pkg.sv | 14 +
 rtl/multi_phase_signal_ctrl_if.sv | 26 ++
 rtl/multi_phase_signal_ctrl_rr_phase_picker.sv | 23 ++
 rtl/multi_phase_signal_ctrl.sv | 135 +++++++++++++
 tb/tb_multi_phase_signal_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/multi_phase_signal_ctrl_pkg.sv
// rtl/multi_phase_signal_ctrl_pkg.sv - shared state encoding and lamp codes for the phase controller
package multi_phase_signal_ctrl_pkg;

  typedef enum logic [1:0] {
    GREEN   = 2'd0,
    YELLOW  = 2'd1,
    ALL_RED = 2'd2
  } state_t;

  localparam logic [2:0] LAMP_G = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_R = 3'b001;

endpackage

// File: rtl/multi_phase_signal_ctrl_if.sv
// rtl/multi_phase_signal_ctrl_if.sv - sensor/timing inputs and lamp outputs of the phase controller
interface multi_phase_signal_ctrl_if #(
  parameter int NUM_PHASES = 4,
  parameter int PH_W       = 2,
  parameter int TIMER_W    = 6
);
  logic [NUM_PHASES-1:0]   car;
  logic [TIMER_W-1:0]      green_min;
  logic [TIMER_W-1:0]      yellow_time;
  logic [TIMER_W-1:0]      red_clear;
  logic                    preempt;
  logic [PH_W-1:0]         preempt_phase;
  logic [3*NUM_PHASES-1:0] light;
  logic [PH_W-1:0]         active_phase;
  logic                    phase_start;

  modport master (
    output car, green_min, yellow_time, red_clear, preempt, preempt_phase,
    input  light, active_phase, phase_start
  );

  modport slave (
    input  car, green_min, yellow_time, red_clear, preempt, preempt_phase,
    output light, active_phase, phase_start
  );
endinterface

// File: rtl/multi_phase_signal_ctrl_rr_phase_picker.sv
// rtl/multi_phase_signal_ctrl_rr_phase_picker.sv - round-robin first-pending search starting after the active phase
module multi_phase_signal_ctrl_rr_phase_picker #(
  parameter int NUM_PHASES = 4,
  parameter int PH_W       = 2
) (
  input  logic [NUM_PHASES-1:0] pending,
  input  logic [PH_W-1:0]       active,
  output logic [PH_W-1:0]       pick
);
  int idx;

  // Scan from the farthest offset down so the nearest pending phase wins; falls back to active.
  always_comb begin
    idx  = 0;
    pick = active;
    for (int k = NUM_PHASES - 1; k >= 1; k--) begin
      idx = (int'(active) + k) % NUM_PHASES;
      if (pending[idx]) begin
        pick = PH_W'(idx);
      end
    end
  end
endmodule

// File: rtl/multi_phase_signal_ctrl.sv
// rtl/multi_phase_signal_ctrl.sv - N-phase intersection controller: demand latch, phase timer, round-robin, preemption
module multi_phase_signal_ctrl
  import multi_phase_signal_ctrl_pkg::*;
#(
  parameter int NUM_PHASES = 4,
  parameter int PH_W       = 2,
  parameter int TIMER_W    = 6
) (
  input  logic                      clk,
  input  logic                      rst_n,
  multi_phase_signal_ctrl_if.slave  bus
);
  localparam int unsigned PHASES_U = NUM_PHASES;

  state_t                  state;
  state_t                  state_next;
  logic [TIMER_W-1:0]      timer;
  logic [TIMER_W-1:0]      timer_load;
  logic [TIMER_W-1:0]      dur;
  logic [NUM_PHASES-1:0]   pending;
  logic [NUM_PHASES-1:0]   pending_next;
  logic [NUM_PHASES-1:0]   active_mask;
  logic [PH_W-1:0]         active;
  logic [PH_W-1:0]         next_phase;
  logic [PH_W-1:0]         target;
  logic [PH_W-1:0]         pick;
  logic [PH_W-1:0]         pick_next;
  logic                    phase_start_q;
  logic                    preempt_valid;
  logic                    expired;
  logic                    others_pending;
  logic                    enter_green;
  logic                    enter_all_red;
  logic [3*NUM_PHASES-1:0] light_c;

  multi_phase_signal_ctrl_rr_phase_picker #(
    .NUM_PHASES (NUM_PHASES),
    .PH_W       (PH_W)
  ) u_picker (
    .pending (pending),
    .active  (active),
    .pick    (pick)
  );

  assign preempt_valid  = bus.preempt && (32'(bus.preempt_phase) < PHASES_U);
  assign expired        = (timer == '0);
  assign active_mask    = NUM_PHASES'(1) << active;
  assign others_pending = |(pending & ~active_mask);
  assign pick_next      = preempt_valid ? bus.preempt_phase : pick;
  // A preempt raised during ALL_RED still redirects the upcoming green.
  assign target         = preempt_valid ? bus.preempt_phase : next_phase;
  assign enter_green    = (state == ALL_RED) && (state_next == GREEN);
  assign enter_all_red  = (state == YELLOW) && (state_next == ALL_RED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= GREEN;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      GREEN: begin
        if (preempt_valid) begin
          if (bus.preempt_phase != active) begin
            state_next = YELLOW;
          end
        end else if (expired && others_pending) begin
          state_next = YELLOW;
        end
      end
      YELLOW:  if (expired) state_next = ALL_RED;
      ALL_RED: if (expired) state_next = GREEN;
      default: state_next = GREEN;
    endcase
  end

  always_comb begin
    light_c = {NUM_PHASES{LAMP_R}};
    unique case (state)
      GREEN:   light_c[3*int'(active) +: 3] = LAMP_G;
      YELLOW:  light_c[3*int'(active) +: 3] = LAMP_Y;
      default: ;
    endcase
  end

  assign bus.light        = light_c;
  assign bus.active_phase = active;
  assign bus.phase_start  = phase_start_q;

  // Duration of the state being entered; zero behaves as a single cycle.
  always_comb begin
    dur = bus.red_clear;
    unique case (state_next)
      GREEN:   dur = bus.green_min;
      YELLOW:  dur = bus.yellow_time;
      default: dur = bus.red_clear;
    endcase
    timer_load = (dur == '0) ? '0 : dur - TIMER_W'(1);
  end

  always_comb begin
    pending_next = pending | (bus.car & ~((state == GREEN) ? active_mask : {NUM_PHASES{1'b0}}));
    if (enter_green) begin
      pending_next = pending_next & ~(NUM_PHASES'(1) << target);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer         <= '0;
      pending       <= '0;
      active        <= '0;
      next_phase    <= '0;
      phase_start_q <= 1'b0;
    end else begin
      if (state_next != state) begin
        timer <= timer_load;
      end else if (!expired) begin
        timer <= timer - TIMER_W'(1);
      end
      pending <= pending_next;
      if (enter_all_red) begin
        next_phase <= pick_next;
      end
      if (enter_green) begin
        active <= target;
      end
      phase_start_q <= enter_green;
    end
  end
endmodule

// File: tb/tb_multi_phase_signal_ctrl.sv
// tb/tb_multi_phase_signal_ctrl.sv - randomized and directed bench against a cycle-count reference model
module tb_multi_phase_signal_ctrl;
  localparam int N  = 4;
  localparam int PW = 2;
  localparam int TW = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  multi_phase_signal_ctrl_if #(.NUM_PHASES(N), .PH_W(PW), .TIMER_W(TW)) bus ();

  multi_phase_signal_ctrl #(.NUM_PHASES(N), .PH_W(PW), .TIMER_W(TW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Reference: stage 0=green 1=yellow 2=all-red; a state lasts max(duration,1) cycles counted by m_el.
  int          m_stage, m_phase, m_next, m_el, m_dur;
  logic [N-1:0] m_pend;
  logic        m_ps;

  function automatic logic [3*N-1:0] exp_light();
    logic [3*N-1:0] l;
    for (int i = 0; i < N; i++)
      l[3*i +: 3] = (i != m_phase || m_stage == 2) ? 3'b001 : (m_stage == 0 ? 3'b100 : 3'b010);
    return l;
  endfunction

  function automatic logic [3*N-1:0] reset_light();
    logic [3*N-1:0] l;
    l = {N{3'b001}};
    l[2:0] = 3'b100;
    return l;
  endfunction

  function automatic int lit_count(logic [3*N-1:0] l);
    int c = 0;
    for (int i = 0; i < N; i++) if (l[3*i +: 3] != 3'b001) c++;
    return c;
  endfunction

  function automatic int at_least_1(int d);
    return (d == 0) ? 1 : d;
  endfunction

  task automatic model_reset();
    m_stage = 0; m_phase = 0; m_next = 0; m_el = 0; m_dur = 1; m_pend = '0; m_ps = 1'b0;
  endtask

  task automatic model_step();
    logic [N-1:0] np;
    bit pv, done, others;
    int pp;
    pp     = int'(bus.preempt_phase);
    pv     = bus.preempt && (pp < N);
    done   = (m_el + 1 >= m_dur);
    others = 1'b0;
    for (int i = 0; i < N; i++) if (i != m_phase && m_pend[i]) others = 1'b1;
    np = m_pend;
    for (int i = 0; i < N; i++) if (bus.car[i] && !(m_stage == 0 && i == m_phase)) np[i] = 1'b1;
    m_ps = 1'b0;
    m_el++;
    case (m_stage)
      0: if (pv ? (pp != m_phase) : (done && others)) begin
           m_stage = 1; m_el = 0; m_dur = at_least_1(int'(bus.yellow_time));
         end
      1: if (done) begin
           m_next = m_phase;
           if (pv) m_next = pp;
           else for (int k = N - 1; k >= 1; k--) if (m_pend[(m_phase + k) % N]) m_next = (m_phase + k) % N;
           m_stage = 2; m_el = 0; m_dur = at_least_1(int'(bus.red_clear));
         end
      default: if (done) begin
           m_phase = pv ? pp : m_next;
           np[m_phase] = 1'b0;
           m_stage = 0; m_el = 0; m_dur = at_least_1(int'(bus.green_min)); m_ps = 1'b1;
         end
    endcase
    m_pend = np;
  endtask

  task automatic set_durations(int g, int y, int r);
    bus.green_min = TW'(g); bus.yellow_time = TW'(y); bus.red_clear = TW'(r);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    bus.car = '0; bus.preempt = 1'b0; bus.preempt_phase = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    int pulses = 0;
    set_durations(5, 3, 2);
    rst_n = 1'b0;
    bus.car = '0; bus.preempt = 1'b0; bus.preempt_phase = '0;
    @(negedge clk);
    n_cmp++;
    if (bus.light !== reset_light() || bus.active_phase !== '0 || bus.phase_start !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state light=%h act=%0d ps=%b want light=%h act=0 ps=0",
               bus.light, bus.active_phase, bus.phase_start, reset_light());
    end
    @(posedge clk); #1;
    model_reset();
    rst_n = 1'b1;
    for (int c = 0; c < 100; c++) begin
      bus.car = '0;
      @(negedge clk);
      n_cmp++;
      if (bus.light !== exp_light() || bus.active_phase !== PW'(m_phase) || bus.phase_start !== m_ps) begin
        n_bad++;
        $display("FAIL reset_idle c%0d light=%h act=%0d ps=%b want light=%h act=%0d ps=%b",
                 c, bus.light, bus.active_phase, bus.phase_start, exp_light(), m_phase, m_ps);
      end
      if (bus.phase_start) pulses++;
      model_step();
      @(posedge clk); #1;
    end
    n_cmp++;
    if (pulses !== 0) begin
      n_bad++;
      $display("FAIL reset_idle_pulses got %0d want 0", pulses);
    end
  endtask

  task automatic test_basic_sequence();
    int start_cyc = -1;
    bit p1_green = 1'b0;
    set_durations(5, 3, 2);
    apply_reset();
    for (int c = 0; c < 20; c++) begin
      bus.car = (c == 1) ? 4'b0100 : 4'b0000;
      @(negedge clk);
      n_cmp++;
      if (bus.light !== exp_light() || bus.active_phase !== PW'(m_phase) || bus.phase_start !== m_ps) begin
        n_bad++;
        $display("FAIL basic c%0d light=%h act=%0d ps=%b want light=%h act=%0d ps=%b",
                 c, bus.light, bus.active_phase, bus.phase_start, exp_light(), m_phase, m_ps);
      end
      if (bus.phase_start && start_cyc < 0) start_cyc = c;
      if (bus.light[5:3] == 3'b100) p1_green = 1'b1;
      model_step();
      @(posedge clk); #1;
    end
    n_cmp++;
    if (start_cyc !== 8 || p1_green !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_order start_cycle=%0d phase1_green=%b want 8 and 0", start_cyc, p1_green);
    end
  endtask

  task automatic test_wrap();
    set_durations(2, 1, 1);
    apply_reset();
    for (int c = 0; c < 25; c++) begin
      bus.car = (c == 1) ? 4'b1000 : (c == 6) ? 4'b1010 : 4'b0000;
      @(negedge clk);
      n_cmp++;
      if (bus.light !== exp_light() || bus.active_phase !== PW'(m_phase) || bus.phase_start !== m_ps) begin
        n_bad++;
        $display("FAIL wrap c%0d light=%h act=%0d ps=%b want light=%h act=%0d ps=%b",
                 c, bus.light, bus.active_phase, bus.phase_start, exp_light(), m_phase, m_ps);
      end
      if (c == 10 || c == 24) begin
        n_cmp++;
        if (bus.active_phase !== 2'd1 || bus.light[5:3] !== 3'b100) begin
          n_bad++;
          $display("FAIL wrap_to_1 c%0d act=%0d lamp1=%b want act=1 lamp1=100", c, bus.active_phase, bus.light[5:3]);
        end
      end
      model_step();
      @(posedge clk); #1;
    end
  endtask

  task automatic test_preempt();
    set_durations(10, 3, 2);
    apply_reset();
    for (int c = 0; c < 70; c++) begin
      bus.car = (c == 1) ? 4'b0010 : (c == 10) ? 4'b1000 : (c == 20) ? 4'b0010 : 4'b0000;
      bus.preempt = (c >= 10 && c <= 40);
      bus.preempt_phase = 2'd2;
      @(negedge clk);
      n_cmp++;
      if (bus.light !== exp_light() || bus.active_phase !== PW'(m_phase) || bus.phase_start !== m_ps) begin
        n_bad++;
        $display("FAIL preempt c%0d light=%h act=%0d ps=%b want light=%h act=%0d ps=%b",
                 c, bus.light, bus.active_phase, bus.phase_start, exp_light(), m_phase, m_ps);
      end
      if (c == 11) begin
        n_cmp++;
        if (bus.light[5:3] !== 3'b010) begin
          n_bad++;
          $display("FAIL preempt_cut_green lamp1=%b want 010", bus.light[5:3]);
        end
      end
      if (c == 40) begin
        n_cmp++;
        if (bus.active_phase !== 2'd2 || bus.light[8:6] !== 3'b100) begin
          n_bad++;
          $display("FAIL preempt_hold act=%0d lamp2=%b want act=2 lamp2=100", bus.active_phase, bus.light[8:6]);
        end
      end
      if (c == 42) begin
        n_cmp++;
        if (bus.light[8:6] !== 3'b010) begin
          n_bad++;
          $display("FAIL preempt_release lamp2=%b want 010", bus.light[8:6]);
        end
      end
      model_step();
      @(posedge clk); #1;
    end
  endtask

  task automatic test_zero_durations();
    set_durations(6, 0, 0);
    apply_reset();
    for (int c = 0; c < 40; c++) begin
      bus.car = (c == 1) ? 4'b0010 : (c == 6) ? 4'b0100 : (c == 14) ? 4'b0001 : 4'b0000;
      if (c == 6) bus.green_min = TW'(20);
      @(negedge clk);
      n_cmp++;
      if (bus.light !== exp_light() || bus.active_phase !== PW'(m_phase) || bus.phase_start !== m_ps) begin
        n_bad++;
        $display("FAIL zero c%0d light=%h act=%0d ps=%b want light=%h act=%0d ps=%b",
                 c, bus.light, bus.active_phase, bus.phase_start, exp_light(), m_phase, m_ps);
      end
      if (c == 13 || c == 32 || c == 33) begin
        n_cmp++;
        if (bus.active_phase !== 2'd2 || bus.light[8:6] !== ((c == 33) ? 3'b010 : 3'b100)) begin
          n_bad++;
          $display("FAIL zero_timing c%0d act=%0d lamp2=%b", c, bus.active_phase, bus.light[8:6]);
        end
      end
      model_step();
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    set_durations(3, 4, 2);
    apply_reset();
    for (int c = 0; c < 5; c++) begin
      bus.car = (c == 1) ? 4'b0100 : 4'b0000;
      if (c == 4) begin
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.light !== reset_light() || bus.active_phase !== '0 || bus.phase_start !== 1'b0) begin
          n_bad++;
          $display("FAIL reset_mid light=%h act=%0d ps=%b want light=%h act=0 ps=0",
                   bus.light, bus.active_phase, bus.phase_start, reset_light());
        end
      end else begin
        @(negedge clk);
        model_step();
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
    model_reset();
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      bus.car = '0;
      @(negedge clk);
      n_cmp++;
      if (bus.light !== exp_light() || bus.active_phase !== PW'(m_phase) || bus.phase_start !== m_ps) begin
        n_bad++;
        $display("FAIL reset_mid_after c%0d light=%h act=%0d ps=%b want light=%h act=%0d ps=%b",
                 c, bus.light, bus.active_phase, bus.phase_start, exp_light(), m_phase, m_ps);
      end
      model_step();
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random();
    set_durations(3, 2, 1);
    apply_reset();
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) bus.car[i] = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 29) == 0) begin
        bus.preempt = ~bus.preempt;
        bus.preempt_phase = PW'($urandom_range(0, N - 1));
      end
      if ($urandom_range(0, 49) == 0) bus.green_min = TW'($urandom_range(0, 6));
      if ($urandom_range(0, 49) == 0) bus.yellow_time = TW'($urandom_range(0, 4));
      if ($urandom_range(0, 49) == 0) bus.red_clear = TW'($urandom_range(0, 3));
      @(negedge clk);
      n_cmp++;
      if (bus.light !== exp_light() || bus.active_phase !== PW'(m_phase) || bus.phase_start !== m_ps) begin
        n_bad++;
        $display("FAIL random c%0d light=%h act=%0d ps=%b want light=%h act=%0d ps=%b",
                 c, bus.light, bus.active_phase, bus.phase_start, exp_light(), m_phase, m_ps);
      end
      n_cmp++;
      if (lit_count(bus.light) > 1) begin
        n_bad++;
        $display("FAIL single_right_of_way c%0d lit=%0d want <=1", c, lit_count(bus.light));
      end
      model_step();
      @(posedge clk); #1;
    end
    bus.preempt = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_sequence();
    test_wrap();
    test_preempt();
    test_zero_durations();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
